// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
package avalon_arb_pkg;

    // One-hot FSM encoding
    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StWr     = 4'b0010,
        StRdCmd  = 4'b0100,
        StRdWait = 4'b1000
    } arb_state_e;

    // ceil(log2(n)), but never below 1 so a 1-bit index always exists
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_pick
    import avalon_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IdxW        = clog2_min1(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IdxW-1:0]        last,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IdxW-1:0]        idx,
    output logic                   any_req
);

    // Scan from the farthest offset down so the nearest requester overwrites the rest
    always_comb begin
        int cand;
        grant   = '0;
        idx     = '0;
        any_req = |req;
        cand    = 0;
        for (int off = int'(NUM_MASTERS); off >= 1; off--) begin
            cand = (int'(last) + off) % int'(NUM_MASTERS);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// Shares one non-pipelined Avalon-MM slave between NUM_MASTERS masters, one transaction
// outstanding, round-robin grant held until write accept or read datavalid.
// Optional: AVALON_ARB_FIXED_PRIO_EN gives master 0 absolute priority in IDLE.
module avalon_rr_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BE_W        = 8,
    localparam int unsigned DATA_W     = BE_W * 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata_i,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable_i,
    input  logic [NUM_MASTERS-1:0]        m_write_i,
    input  logic [NUM_MASTERS-1:0]        m_read_i,
    output logic [NUM_MASTERS-1:0]        m_waitrequest_o,
    output logic [DATA_W-1:0]             m_readdata_o,
    output logic [NUM_MASTERS-1:0]        m_datavalid_o,
    output logic [ADDR_W-1:0]             s_address_o,
    output logic [DATA_W-1:0]             s_writedata_o,
    output logic [BE_W-1:0]               s_byteenable_o,
    output logic                          s_write_o,
    output logic                          s_read_o,
    input  logic [DATA_W-1:0]             s_readdata_i,
    input  logic                          s_datavalid_i,
    input  logic                          s_waitrequest_i
);

    localparam int unsigned IdxW = clog2_min1(NUM_MASTERS);
`ifdef AVALON_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic                  done;

    logic [NUM_MASTERS-1:0] req, req_rr, pick_grant, sel_onehot;
    logic [IdxW-1:0]        pick_idx, sel_idx;
    logic                   pick_any, prio0, any_sel;

    logic [ADDR_W-1:0]      cur_addr;
    logic [DATA_W-1:0]      cur_data;
    logic [BE_W-1:0]        cur_be;

    assign req    = m_read_i | m_write_i;
    // With fixed priority, master 0 is taken out of the rotation entirely
    assign req_rr = FixedPrio ? (req & ~NUM_MASTERS'(1)) : req;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IdxW        (IdxW)
    ) u_rr_pick (
        .req     (req_rr),
        .last    (last_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign prio0      = FixedPrio && req[0];
    assign sel_onehot = prio0 ? NUM_MASTERS'(1) : pick_grant;
    assign sel_idx    = prio0 ? '0 : pick_idx;
    assign any_sel    = pick_any | prio0;

    assign cur_addr = m_address_i[int'(grant_q) * ADDR_W +: ADDR_W];
    assign cur_data = m_writedata_i[int'(grant_q) * DATA_W +: DATA_W];
    assign cur_be   = m_byteenable_i[int'(grant_q) * BE_W +: BE_W];

    assign m_readdata_o = s_readdata_i;

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdxW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        done            = 1'b0;
        m_waitrequest_o = '1;
        m_datavalid_o   = '0;
        s_write_o       = 1'b0;
        s_read_o        = 1'b0;
        s_address_o     = '0;
        s_writedata_o   = '0;
        s_byteenable_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (any_sel) begin
                    grant_d = sel_idx;
                    state_d = (|(sel_onehot & m_read_i)) ? StRdCmd : StWr;
                end
            end
            StWr: begin
                s_write_o      = 1'b1;
                s_address_o    = cur_addr;
                s_writedata_o  = cur_data;
                s_byteenable_o = cur_be;
                if (!s_waitrequest_i) begin
                    m_waitrequest_o[grant_q] = 1'b0;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdCmd: begin
                s_read_o       = 1'b1;
                s_address_o    = cur_addr;
                s_byteenable_o = cur_be;
                if (!s_waitrequest_i) begin
                    m_waitrequest_o[grant_q] = 1'b0;
                    if (s_datavalid_i) begin
                        m_datavalid_o[grant_q] = 1'b1;
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (s_datavalid_i) begin
                    m_datavalid_o[grant_q] = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Master 0 wins by priority, so it never moves the rotation pointer
        if (done && !(FixedPrio && grant_q == '0)) begin
            last_d = grant_q;
        end
    end

endmodule
